// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues word-addressed reads to instruction memory,
// buffers the responses in a small FIFO for IF/ID, and stops fetching at an HLT word.
module instr_fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [5:0]  HLT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    cnt_t        r_count;
    ptr_t        r_rd_ptr;
    ptr_t        r_wr_ptr;
    logic        r_halted;
    logic [31:0] r_q_instr [DEPTH];
    logic [31:0] r_q_pc    [DEPTH];

    logic w_nonempty;
    logic w_push;
    logic w_push_hlt;
    logic w_pop;
    logic w_credit;

    // A response is kept only if nothing has killed it: redirect, halt, or reset.
    assign w_push     = reset && r_inflight && !r_halted && !redirect;
    assign w_push_hlt = w_push && (imem_rdata[31:26] == HLT_OPCODE);
    assign w_nonempty = (r_count != '0);
    assign w_pop      = if_valid && id_ready;
    // Credit counts the in-flight word as already occupying a slot, so a push never overflows.
    assign w_credit   = (r_count + cnt_t'(r_inflight)) < cnt_t'(DEPTH);

    assign imem_req  = reset && !r_halted && !redirect && !w_push_hlt && w_credit;
    assign imem_addr = reset ? r_fetch_pc : RESET_PC;
    assign if_valid  = reset && w_nonempty;
    assign if_instr  = if_valid ? r_q_instr[r_rd_ptr] : 32'h0;
    assign if_pc     = if_valid ? r_q_pc[r_rd_ptr]    : 32'h0;
    assign halted    = r_halted;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_halted      <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_halted   <= 1'b0;
        end else begin
            if (imem_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd1;
            end
            r_inflight    <= imem_req;
            r_inflight_pc <= r_fetch_pc;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_hlt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // NOTE: queue storage is not reset; the count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios with hand-computed
// expectations plus a randomized phase, all compared against a queue-level model.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [5:0]  HLT      = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .HLT_OPCODE (HLT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory contents: one configurable HLT word, everything else a tagged address.
    logic        hlt_en   = 1'b0;
    logic [31:0] hlt_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (hlt_en && a == hlt_addr) return {HLT, a[25:0]};
        return 32'h1000_0000 + a;
    endfunction

    logic        m_req_q  = 1'b0;
    logic [31:0] m_addr_q = 32'h0;

    always @(negedge clk) begin
        m_req_q  = imem_req;
        m_addr_q = imem_addr;
    end

    always @(posedge clk) begin
        imem_rdata <= m_req_q ? mem_word(m_addr_q) : $urandom();
    end

    // Reference model: a queue of {pc, instr} entries plus at most one word in flight.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    bit          m_inflight = 1'b0;
    entry_t      m_fly;
    logic [31:0] m_pc       = RESET_PC;
    bit          m_halted   = 1'b0;
    bit          model_on   = 1'b0;

    always @(negedge clk) begin : model
        bit          arrive;
        bit          hlt_arrive;
        bit          e_req;
        bit          e_valid;
        logic [31:0] e_addr;
        if (model_on) begin
            arrive     = reset && m_inflight && !m_halted && !redirect;
            hlt_arrive = arrive && (m_fly.instr[31:26] == HLT);
            e_req      = reset && !m_halted && !redirect && !hlt_arrive
                         && (mq.size() + int'(m_inflight) < DEPTH);
            e_valid    = reset && (mq.size() != 0);
            e_addr     = reset ? m_pc : RESET_PC;

            check("model imem_req",  32'(imem_req), 32'(e_req));
            check("model imem_addr", imem_addr, e_addr);
            check("model if_valid",  32'(if_valid), 32'(e_valid));
            check("model halted",    32'(halted), 32'(m_halted));
            if (e_valid) begin
                check("model if_pc",    if_pc,    mq[0].pc);
                check("model if_instr", if_instr, mq[0].instr);
            end

            if (!reset) begin
                mq.delete();
                m_inflight = 1'b0;
                m_pc       = RESET_PC;
                m_halted   = 1'b0;
            end else if (redirect) begin
                mq.delete();
                m_inflight = 1'b0;
                m_pc       = redirect_pc;
                m_halted   = 1'b0;
            end else begin
                if (e_valid && id_ready) void'(mq.pop_front());
                if (arrive) begin
                    mq.push_back(m_fly);
                    if (hlt_arrive) m_halted = 1'b1;
                end
                m_inflight = e_req;
                if (e_req) begin
                    m_fly.pc    = m_pc;
                    m_fly.instr = mem_word(m_pc);
                    m_pc        = m_pc + 32'd1;
                end
            end
        end
    end

    // Holds reset low across one edge and returns at the start of the first released cycle.
    task automatic do_reset();
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;

        step();
        model_on = 1'b1;
        @(negedge clk);
        check("reset imem_req",  32'(imem_req), 32'd0);
        check("reset imem_addr", imem_addr, RESET_PC);
        check("reset if_valid",  32'(if_valid), 32'd0);
        check("reset if_instr",  if_instr, 32'd0);
        check("reset if_pc",     if_pc, 32'd0);

        // Streaming from reset release: request in cycle 1, head valid in cycle 3.
        step();
        reset    = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        check("stream c1 imem_req",  32'(imem_req), 32'd1);
        check("stream c1 imem_addr", imem_addr, 32'd0);
        check("stream c1 if_valid",  32'(if_valid), 32'd0);
        step();
        @(negedge clk);
        check("stream c2 if_valid", 32'(if_valid), 32'd0);
        step();
        @(negedge clk);
        check("stream c3 if_valid", 32'(if_valid), 32'd1);
        check("stream c3 if_pc",    if_pc, 32'd0);
        check("stream c3 if_instr", if_instr, 32'h1000_0000);
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            check("stream if_pc",    if_pc, 32'(k));
            check("stream if_instr", if_instr, 32'h1000_0000 + 32'(k));
        end

        // Backpressure: the queue fills to DEPTH and stops requesting, then drains in order.
        id_ready = 1'b0;
        do_reset();
        repeat (10) step();
        id_ready = 1'b1;
        @(negedge clk);
        check("full if_valid", 32'(if_valid), 32'd1);
        check("full imem_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("drain if_pc", if_pc, 32'(k));
            step();
            @(negedge clk);
        end

        // Redirect with three entries queued and one response in flight.
        id_ready = 1'b0;
        do_reset();
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 32'h17;
        @(negedge clk);
        check("redir c5 if_valid", 32'(if_valid), 32'd1);
        check("redir c5 imem_req", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        check("redir c6 if_valid",  32'(if_valid), 32'd0);
        check("redir c6 imem_addr", imem_addr, 32'h17);
        check("redir c6 imem_req",  32'(imem_req), 32'd1);
        step();
        @(negedge clk);
        check("redir c7 if_valid", 32'(if_valid), 32'd0);
        step();
        @(negedge clk);
        check("redir c8 if_valid", 32'(if_valid), 32'd1);
        check("redir c8 if_pc",    if_pc, 32'h17);
        check("redir c8 if_instr", if_instr, 32'h1000_0017);

        // Halt at address 26, then resume via redirect to 0.
        hlt_en   = 1'b1;
        hlt_addr = 32'd26;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_valid && if_pc == 32'd26) begin
                found = 1'b1;
                check("halt word instr", if_instr, {HLT, 26'd26});
                break;
            end
            step();
        end
        check("halt word reached", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check("halted flag",     32'(halted), 32'd1);
            check("halted imem_req", 32'(imem_req), 32'd0);
            check("halted if_valid", 32'(if_valid), 32'd0);
        end
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        hlt_en      = 1'b0;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("resume halted",    32'(halted), 32'd0);
        check("resume imem_addr", imem_addr, 32'd0);
        check("resume imem_req",  32'(imem_req), 32'd1);

        // Redirect coinciding with a pop.
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        check("simul pop if_valid", 32'(if_valid), 32'd1);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("simul next if_valid", 32'(if_valid), 32'd0);

        // One-cycle reset in mid-stream.
        repeat (5) step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst imem_req",  32'(imem_req), 32'd0);
        check("midrst imem_addr", imem_addr, RESET_PC);
        check("midrst if_valid",  32'(if_valid), 32'd0);
        check("midrst if_instr",  if_instr, 32'd0);
        check("midrst if_pc",     if_pc, 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("postrst imem_req",  32'(imem_req), 32'd1);
        check("postrst imem_addr", imem_addr, RESET_PC);
        check("postrst if_valid",  32'(if_valid), 32'd0);

        // fetch_pc wraps from 32'hFFFFFFFF to 0.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("wrap pc fffffffe", if_pc, 32'hFFFF_FFFE);
        step();
        @(negedge clk);
        check("wrap pc ffffffff", if_pc, 32'hFFFF_FFFF);
        step();
        @(negedge clk);
        check("wrap pc 0",     if_pc, 32'h0);
        check("wrap instr 0",  if_instr, 32'h1000_0000);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset    = ($urandom_range(0, 199) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           redirect_pc = 32'($urandom_range(0, 100));
            id_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) begin
                hlt_en   = $urandom_range(0, 1) == 1;
                hlt_addr = 32'($urandom_range(0, 120));
            end
        end
        step();
        reset    = 1'b1;
        redirect = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of prefetch queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, word address fetched first after reset.
REQ-003 The block SHALL have parameter HLT_OPCODE, default 6'b111111, opcode (instr[31:26]) that stops fetching.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, named as below; all state SHALL change only on the rising edge of clk.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32, word address of the request.
REQ-009 The block SHALL have port imem_rdata, input, 32, read data, valid exactly one cycle after imem_req.
REQ-010 The block SHALL have port if_valid, output, 1, queue head valid toward IF/ID.
REQ-011 The block SHALL have port if_instr, output, 32, instruction at the queue head.
REQ-012 The block SHALL have port if_pc, output, 32, word address of if_instr.
REQ-013 The block SHALL have port id_ready, input, 1, the decode stage accepts the head this cycle.
REQ-014 The block SHALL have port redirect, input, 1, branch/jump/call/ret taken; flush and refetch.
REQ-015 The block SHALL have port redirect_pc, input, 32, new fetch word address.
REQ-016 The block SHALL have port halted, output, 1, an HLT word has been enqueued and fetching has stopped.

Function
REQ-017 fetch_pc SHALL be a 32-bit register driving imem_addr and SHALL increment by 1 (word addressing) per issued request, wrapping 32'hFFFFFFFF->0.
REQ-018 imem_req SHALL assert only when !halted && !redirect && (count + inflight) < DEPTH, where inflight (0/1) marks a request issued last cycle.
REQ-019 The response SHALL be captured the cycle after the request, paired with the address that was issued, and pushed into the queue unless it has been killed.
REQ-020 A handshake (pop) SHALL occur when if_valid && id_ready; if_instr/if_pc SHALL present the oldest entry, and if_valid SHALL equal (count != 0).
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged; the credit rule in REQ-018 SHALL make overflow impossible.
REQ-022 Pointers SHALL wrap modulo DEPTH; when count==0, id_ready SHALL have no effect.
REQ-023 On redirect: the queue SHALL flush (count<=0), the in-flight response SHALL be killed, halted SHALL clear, and fetch_pc<=redirect_pc; the first request to redirect_pc SHALL issue the cycle after redirect.
REQ-024 A redirect coinciding with a pop SHALL have priority; the pop counts as consumed, and if_valid SHALL be 0 in the next cycle.
REQ-025 A redirect coinciding with a response SHALL discard that response.
REQ-026 When a pushed word has instr[31:26]==HLT_OPCODE, that word SHALL be enqueued, halted SHALL be set in the next cycle, and imem_req SHALL be suppressed combinationally in the same cycle.
REQ-027 Any later response SHALL be discarded while halted=1.
REQ-028 While halted=1, queued entries SHALL continue to drain normally; only redirect or reset SHALL clear halted.
REQ-029 Latency SHALL be: request at cycle N, response at N+1, if_valid at N+2 when the queue was empty.

Reset
REQ-030 While reset==0 at a clock edge, the block SHALL set fetch_pc<=RESET_PC, count<=0, pointers<=0, inflight<=0, and halted<=0.
REQ-031 While reset==0 at a clock edge, outputs SHALL be imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, and if_pc=0.
REQ-032 Assertion of reset mid-operation SHALL discard all queued and in-flight data; the first request after release SHALL be to RESET_PC on the first edge with reset==1.
REQ-033 Reset SHALL take priority over redirect.

Verification
REQ-034 Streaming: reset release, id_ready=1, memory returns 32'h1000_0000+addr -> if_valid first at cycle 3; consecutive if_pc 0,1,2,3..., and if_instr matches the address.
REQ-035 Backpressure: id_ready=0 for 10 cycles -> exactly DEPTH=4 entries held with if_pc=0..3 and imem_req=0 once full; id_ready=1 -> entries 0..3 drain in order with no loss or duplication.
REQ-036 Redirect: redirect=1 with redirect_pc=32'h17 while 3 entries are queued and a response is in flight -> next cycle if_valid=0 and imem_addr=32'h17; the next delivered if_pc=32'h17 and no stale word appears.
REQ-037 Halt: word at address 26 has opcode HLT_OPCODE -> the word at address 26 is delivered; halted=1; no further imem_req; words after 26 are never delivered; redirect to 0 -> fetching resumes at 0.
REQ-038 Simultaneous/reset: redirect with pop in the same cycle -> head consumed once and queue empty; reset=0 asserted mid-stream for 1 cycle -> all outputs at reset values and the next request is to addr 0.
